// File: rtl/range_kernel_ctrl.sv
// Range-kernel sequencer: gates 7x7 window issue, tracks in-flight windows and
// swaps sigma only on an empty pipe. Define RANGE_KERNEL_CTRL_WDOG_EN for a drain watchdog.
module range_kernel_ctrl #(
  parameter int unsigned LATENCY       = 10,
  parameter int unsigned SIGMA_SETTLE  = 8,
  parameter int unsigned SIGMA_DEFAULT = 10,
  parameter int unsigned CNT_W         = 5,
  localparam int unsigned SIGMA_W      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SIGMA_W-1:0] cfg_sigma,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic               win_in_valid,
  output logic               win_in_ready,
  output logic               win_out_valid,
  output logic [SIGMA_W-1:0] sigma,
  input  logic               kernel_valid,
  output logic [CNT_W-1:0]   inflight,
  output logic               busy,
  output logic [2:0]         err
);

  localparam int unsigned SET_W = (SIGMA_SETTLE > 1) ? $clog2(SIGMA_SETTLE) : 1;

  // The counter must hold a full pipe plus the window issued on the drain cycle.
  if ((64'd1 << CNT_W) <= 64'(LATENCY) + 64'd1) begin : g_cnt_w_check
    $error("range_kernel_ctrl: CNT_W too small for LATENCY");
  end

  typedef enum logic [1:0] {RUN, DRAIN, APPLY, SETTLE} state_e;

  state_e             state_q, state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [SIGMA_W-1:0] sigma_q, sigma_d;
  logic [SIGMA_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]   inflight_q, inflight_d;
  logic [2:0]         err_q, err_d;
  logic               issue;

`ifdef RANGE_KERNEL_CTRL_WDOG_EN
  localparam int unsigned WDOG_LIMIT = 4 * LATENCY;
  localparam int unsigned WDOG_W     = (WDOG_LIMIT > 1) ? $clog2(WDOG_LIMIT) : 1;
  logic [WDOG_W-1:0] wdog_q, wdog_d;
`endif

  assign win_in_ready  = (state_q == RUN);
  assign cfg_ready     = (state_q == RUN);
  assign busy          = (state_q != RUN);
  assign issue         = win_in_valid && win_in_ready;
  assign win_out_valid = issue;
  assign sigma         = sigma_q;
  assign inflight      = inflight_q;
  assign err           = err_q;

  // Next-state, in-flight accounting and sigma update.
  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    sigma_d    = sigma_q;
    pending_d  = pending_q;
    inflight_d = inflight_q;
    err_d      = err_q;
`ifdef RANGE_KERNEL_CTRL_WDOG_EN
    wdog_d     = '0;
`else
    err_d[2]   = 1'b0;
`endif

    if (kernel_valid && (inflight_q == '0)) begin
      err_d[0] = 1'b1;
    end
    if (issue && !kernel_valid) begin
      inflight_d = inflight_q + CNT_W'(1);
    end else if (!issue && kernel_valid && (inflight_q != '0)) begin
      inflight_d = inflight_q - CNT_W'(1);
    end

    case (state_q)
      RUN: begin
        if (cfg_valid) begin
          if (cfg_sigma == '0) begin
            err_d[1] = 1'b1;
          end else if (cfg_sigma != sigma_q) begin
            pending_d = cfg_sigma;
            state_d   = DRAIN;
          end
        end
      end
      DRAIN: begin
`ifdef RANGE_KERNEL_CTRL_WDOG_EN
        wdog_d = wdog_q + WDOG_W'(1);
`endif
        if (inflight_d == '0) begin
          state_d = APPLY;
`ifdef RANGE_KERNEL_CTRL_WDOG_EN
        end else if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
          // Kernel lost returns: abandon the count rather than hang.
          inflight_d = '0;
          err_d[2]   = 1'b1;
          state_d    = APPLY;
`endif
        end
      end
      APPLY: begin
        sigma_d  = pending_q;
        settle_d = SET_W'(SIGMA_SETTLE - 1);
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q - SET_W'(1);
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SETTLE;
      settle_q   <= SET_W'(SIGMA_SETTLE - 1);
      sigma_q    <= SIGMA_W'(SIGMA_DEFAULT);
      pending_q  <= '0;
      inflight_q <= '0;
      err_q      <= '0;
`ifdef RANGE_KERNEL_CTRL_WDOG_EN
      wdog_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      sigma_q    <= sigma_d;
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      err_q      <= err_d;
`ifdef RANGE_KERNEL_CTRL_WDOG_EN
      wdog_q     <= wdog_d;
`endif
    end
  end

endmodule

// File: tb/tb_range_kernel_ctrl.sv
// Self-checking bench for range_kernel_ctrl: directed steps plus random traffic
// against a cycle-level behavioural model with an ideal fixed-latency kernel.
module tb_range_kernel_ctrl;

  localparam int unsigned LAT    = 10;
  localparam int unsigned SETTLE = 8;
  localparam int unsigned CNT_W  = 5;
`ifdef RANGE_KERNEL_CTRL_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  logic             clk, rst_n;
  logic [9:0]       cfg_sigma;
  logic             cfg_valid, cfg_ready;
  logic             win_in_valid, win_in_ready, win_out_valid;
  logic [9:0]       sigma;
  logic             kernel_valid;
  logic [CNT_W-1:0] inflight;
  logic             busy;
  logic [2:0]       err;

  range_kernel_ctrl #(
    .LATENCY(LAT), .SIGMA_SETTLE(SETTLE), .SIGMA_DEFAULT(10), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_sigma(cfg_sigma), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .win_in_valid(win_in_valid), .win_in_ready(win_in_ready), .win_out_valid(win_out_valid),
    .sigma(sigma), .kernel_valid(kernel_valid), .inflight(inflight),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Kernel: each issued window returns LAT cycles later, tagged with its issue-time sigma.
  typedef struct {
    int         due;
    logic [9:0] sig;
  } ret_t;
  ret_t kq[$];
  bit   inject_kv = 1'b0;
  bit   suppress  = 1'b0;

  // Behavioural model: "stall" = remaining non-issue cycles after the drain completes.
  int         m_cnt, m_hold, m_dcyc;
  logic [2:0] m_err;
  logic [9:0] m_sigma, m_pend;
  bit         m_drain, m_apply;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic m_reset();
    m_cnt = 0; m_err = 3'b000; m_sigma = 10'd10; m_pend = 10'd0;
    m_drain = 1'b0; m_apply = 1'b0; m_hold = SETTLE; m_dcyc = 0;
  endtask

  // One clock cycle: drive at negedge, compare at negedge+1, advance model.
  task automatic step(input logic wiv, input logic cv, input logic [9:0] cs);
    logic       kv, ret;
    logic [9:0] ret_sig;
    bit         run, iss;
    ret_t       e;
    kv = inject_kv; inject_kv = 1'b0; ret = 1'b0; ret_sig = '0;
    if (suppress) begin
      while (kq.size() > 0 && kq[0].due <= cyc) kq.delete(0);
    end else if (kq.size() > 0 && kq[0].due == cyc) begin
      kv = 1'b1; ret = 1'b1; ret_sig = kq[0].sig; kq.delete(0);
    end
    win_in_valid = wiv; cfg_valid = cv; cfg_sigma = cs; kernel_valid = kv;
    #1;
    run = !m_drain && (m_hold == 0);
    iss = run && wiv;
    chk("win_in_ready", 32'(win_in_ready), 32'(run));
    chk("cfg_ready", 32'(cfg_ready), 32'(run));
    chk("busy", 32'(busy), 32'(!run));
    chk("win_out_valid", 32'(win_out_valid), 32'(iss));
    chk("sigma", 32'(sigma), 32'(m_sigma));
    chk("inflight", 32'(inflight), 32'(m_cnt));
    chk("err", 32'(err), 32'(m_err));
    if (ret) chk("ret_sigma_stable", 32'(sigma), 32'(ret_sig));

    if (kv && m_cnt == 0) m_err[0] = 1'b1;
    if (iss && !kv) m_cnt++;
    else if (!iss && kv && m_cnt > 0) m_cnt--;
    if (iss) begin
      e.due = cyc + LAT; e.sig = m_sigma; kq.push_back(e);
    end
    if (run) begin
      if (cv && cs == 10'd0) m_err[1] = 1'b1;
      else if (cv && cs != m_sigma) begin
        m_drain = 1'b1; m_pend = cs; m_dcyc = 0;
      end
    end else if (m_drain) begin
      m_dcyc++;
      if (m_cnt == 0 || (WDOG && m_dcyc >= 4 * LAT)) begin
        if (m_cnt != 0) m_err[2] = 1'b1;
        m_cnt = 0; m_drain = 1'b0; m_hold = SETTLE + 1; m_apply = 1'b1;
      end
    end else begin
      if (m_apply) begin
        m_sigma = m_pend; m_apply = 1'b0;
      end
      m_hold--;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    win_in_valid = 1'b0; cfg_valid = 1'b0; cfg_sigma = '0; kernel_valid = 1'b0;
    kq.delete(); inject_kv = 1'b0; suppress = 1'b0;
    m_reset();
    #1;
    chk("rst_win_in_ready", 32'(win_in_ready), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd0);
    chk("rst_win_out_valid", 32'(win_out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_sigma", 32'(sigma), 32'd10);
    chk("rst_inflight", 32'(inflight), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] cs, old_sigma, new_sigma;
    int         r;
    rst_n = 1'b0;
    @(negedge clk);
    do_reset();

    // Reset release with windows always available; pipe fills to LAT.
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, '0);
    chk("fill_inflight", 32'(inflight), 32'(LAT));
    chk("fill_sigma", 32'(sigma), 32'd10);

    // Real change to 20 under full streaming.
    step(1'b1, 1'b1, 10'd20);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, '0);
    chk("chg_sigma", 32'(sigma), 32'd20);
    chk("chg_busy", 32'(busy), 32'd0);

    // Unchanged sigma: no bubble.
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 10'd20);
      chk("same_busy", 32'(busy), 32'd0);
    end

    // Zero sigma request is dropped and flagged.
    step(1'b1, 1'b1, 10'd0);
    chk("zero_err", 32'(err), 32'b010);
    chk("zero_sigma", 32'(sigma), 32'd20);
    chk("zero_busy", 32'(busy), 32'd0);

    // Drain, then spurious return on an empty pipe.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0);
    inject_kv = 1'b1;
    step(1'b0, 1'b0, '0);
    chk("uflow_err", 32'(err), 32'b011);
    chk("uflow_inflight", 32'(inflight), 32'd0);

    // Return coincident with an issue at inflight=5.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0);
    chk("coinc_before", 32'(inflight), 32'd5);
    step(1'b1, 1'b0, '0);
    chk("coinc_after", 32'(inflight), 32'd5);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0);

    // Random traffic with occasional sigma requests.
    for (int i = 0; i < 700; i++) begin
      r = int'($urandom_range(0, 3));
      case (r)
        0:       cs = 10'd0;
        1:       cs = m_sigma;
        2:       cs = 10'($urandom_range(1, 1023));
        default: cs = ($urandom_range(0, 1) == 0) ? 10'd10 : 10'd20;
      endcase
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0), cs);
    end

    // Lost returns during a drain.
    for (int i = 0; i < 25; i++) step(1'b1, 1'b0, '0);
    for (int i = 0; i < 20 && busy; i++) step(1'b0, 1'b0, '0);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, '0);
    old_sigma = sigma;
    new_sigma = (old_sigma == 10'd33) ? 10'd34 : 10'd33;
    step(1'b1, 1'b1, new_sigma);
    suppress = 1'b1;
    for (int i = 0; i < 60; i++) step(1'b1, 1'b0, '0);
    suppress = 1'b0;
    chk("wdog_err2", 32'(err[2]), 32'(WDOG));
    chk("wdog_busy", 32'(busy), 32'(!WDOG));
    chk("wdog_sigma", 32'(sigma), WDOG ? 32'(new_sigma) : 32'(old_sigma));
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, '0);

    // Reset mid-stream.
    do_reset();
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, '0);
    chk("rst2_inflight", 32'(inflight), 32'(LAT));
    chk("rst2_err", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
